// File: rtl/fifo_stream_reader.sv
// Drains the 32-bit strobe FIFO into a valid/ready stream with packet framing (m_last).
// Define STREAM_PARITY_EN to add m_parity, the even parity of m_data carried with each word.
module fifo_stream_reader #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PKT_LEN = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              fifo_rd,
  output logic              fifo_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy
`ifdef STREAM_PARITY_EN
  ,
  output logic              m_parity
`endif
);

  localparam int unsigned      CNT_W    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PKT_LEN - 1);

  logic [1:0]        occ;
  logic [1:0]        occ_next;
  logic              inflight;
  logic              pop;
  logic [DATA_W-1:0] skid;
  logic [CNT_W-1:0]  wcnt;
  logic [CNT_W-1:0]  wcnt_next;
  logic              head_from_skid;
  logic              head_from_fifo;
  logic              skid_from_fifo;

  // Issue rule counts the word already in flight so the 2-entry buffer can never overflow.
  always_comb begin
    pop       = m_valid & m_ready;
    occ_next  = occ + 2'(inflight) - 2'(pop);
    fifo_rd   = !rst & enable & !fifo_empty & (occ_next < 2'd2);
    fifo_en   = fifo_rd;
    wcnt_next = wcnt;
    if (pop) begin
      wcnt_next = (wcnt == LAST_IDX) ? '0 : wcnt + CNT_W'(1);
    end
  end

  // A captured word lands in head only when head is (or is becoming) empty; otherwise in skid.
  always_comb begin
    head_from_skid = pop && (occ == 2'd2);
    head_from_fifo = inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop));
    skid_from_fifo = inflight && (((occ == 2'd1) && !pop) || ((occ == 2'd2) && pop));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      wcnt     <= '0;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      busy     <= 1'b0;
      m_data   <= '0;
      skid     <= '0;
    end else begin
      occ      <= occ_next;
      inflight <= fifo_rd;
      wcnt     <= wcnt_next;
      m_valid  <= (occ_next != 2'd0);
      m_last   <= (occ_next != 2'd0) && (wcnt_next == LAST_IDX);
      busy     <= (occ_next != 2'd0) | fifo_rd;
      if (head_from_skid) begin
        m_data <= skid;
      end else if (head_from_fifo) begin
        m_data <= fifo_dout;
      end
      if (skid_from_fifo) begin
        skid <= fifo_dout;
      end
    end
  end

`ifdef STREAM_PARITY_EN
  logic skid_par;

  // Parity is computed once at capture and follows its word through the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_parity <= 1'b0;
      skid_par <= 1'b0;
    end else begin
      if (head_from_skid) begin
        m_parity <= skid_par;
      end else if (head_from_fifo) begin
        m_parity <= ^fifo_dout;
      end
      if (skid_from_fifo) begin
        skid_par <= ^fifo_dout;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, in-order stream scoreboard, directed and random phases.
module tb_fifo_stream_reader;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned PKT_LEN = 4;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              fifo_rd;
  logic              fifo_en;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;
  logic              busy;
`ifdef STREAM_PARITY_EN
  logic              m_parity;
`endif

  // Behavioural strobe FIFO: dataOut registered on the read edge.
  logic [DATA_W-1:0] mem [256];
  logic [7:0]        wr_ptr = '0;
  logic [7:0]        rd_ptr = '0;
  assign fifo_empty = (wr_ptr == rd_ptr);

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_ptr = '0;
  int         pkt_idx = 0;
  int         delivered = 0;
  int         last_cnt = 0;

  fifo_stream_reader #(.DATA_W(DATA_W), .PKT_LEN(PKT_LEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_rd    (fifo_rd),
    .fifo_en    (fifo_en),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy)
`ifdef STREAM_PARITY_EN
    ,
    .m_parity   (m_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_rd) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // Stream scoreboard: output must be the FIFO contents in order, framed every PKT_LEN words.
  always @(negedge clk) begin
    if (rst) begin
      exp_ptr <= rd_ptr;
      pkt_idx <= 0;
    end else begin
      chk("rd_when_empty", 32'(fifo_rd & fifo_empty), 32'd0);
      chk("rd_when_disabled", 32'(fifo_rd & !enable), 32'd0);
      chk("last_unqualified", 32'(m_last & !m_valid), 32'd0);
      if (m_valid) begin
        chk("stream_data", m_data, mem[exp_ptr]);
        chk("stream_last", 32'(m_last), 32'(pkt_idx == int'(PKT_LEN) - 1));
`ifdef STREAM_PARITY_EN
        chk("stream_parity", 32'(m_parity), 32'(^mem[exp_ptr]));
`endif
        if (m_ready) begin
          exp_ptr   <= exp_ptr + 8'd1;
          pkt_idx   <= (pkt_idx + 1) % int'(PKT_LEN);
          delivered <= delivered + 1;
          if (pkt_idx == int'(PKT_LEN) - 1) last_cnt <= last_cnt + 1;
        end
      end
    end
  end

  initial begin
    logic [31:0] p2 [3];
    int rd_seen;
    int d0;
    int l0;
    p2 = '{32'hA1, 32'hA2, 32'hA3};
    rst = 1'b1;
    enable = 1'b1;
    m_ready = 1'b1;
    #1;
    chk("rst_rd", 32'(fifo_rd), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", m_data, 32'd0);
    chk("rst_last", 32'(m_last), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    cyc();
    rst = 1'b0;

    // Empty FIFO: nothing happens.
    for (int k = 0; k < 10; k++) begin
      cyc();
      #1;
      chk("idle_rd", 32'(fifo_rd), 32'd0);
      chk("idle_valid", 32'(m_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end

    // Three words at full rate, two-edge latency.
    cyc();
    push(32'hA1); push(32'hA2); push(32'hA3);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc();
      #1;
      chk("p2_rd", 32'(fifo_rd), 32'(k < 3));
      chk("p2_en", 32'(fifo_en), 32'(k < 3));
      chk("p2_valid", 32'(m_valid), 32'(k >= 2 && k <= 4));
      chk("p2_busy", 32'(busy), 32'(k >= 1 && k <= 4));
      if (k >= 2 && k <= 4) chk("p2_data", m_data, p2[k-2]);
    end

    // Backpressure: only two reads, head held, then gapless drain.
    do_reset();
    m_ready = 1'b0;
    rd_seen = 0;
    for (int i = 0; i < 5; i++) push(32'hB0 + 32'(i));
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      #1;
      rd_seen += 32'(fifo_rd);
      if (k >= 2) begin
        chk("p3_hold_valid", 32'(m_valid), 32'd1);
        chk("p3_hold_data", m_data, 32'hB0);
      end
    end
    chk("p3_reads", 32'(rd_seen), 32'd2);
    cyc();
    m_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) cyc();
      #1;
      chk("p3_valid", 32'(m_valid), 32'(k < 5));
      if (k < 5) chk("p3_data", m_data, 32'hB0 + 32'(k));
    end

    // Framing over 9 words with PKT_LEN=4.
    do_reset();
    d0 = delivered;
    l0 = last_cnt;
    for (int i = 0; i < 9; i++) push(32'hC0 + 32'(i));
    repeat (14) cyc();
    #1;
    chk("p4_count", 32'(delivered - d0), 32'd9);
    chk("p4_lasts", 32'(last_cnt - l0), 32'd2);

    // Reset with a full buffer; framing restarts afterwards.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'hD0 + 32'(i));
    repeat (5) cyc();
    #1;
    chk("p5_full_valid", 32'(m_valid), 32'd1);
    chk("p5_full_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("p5_rst_valid", 32'(m_valid), 32'd0);
    chk("p5_rst_data", m_data, 32'd0);
    chk("p5_rst_last", 32'(m_last), 32'd0);
    chk("p5_rst_busy", 32'(busy), 32'd0);
    chk("p5_rst_rd", 32'(fifo_rd), 32'd0);
    cyc();
    rst = 1'b0;
    push(32'hD4); push(32'hD5);
    m_ready = 1'b1;
    d0 = delivered;
    l0 = last_cnt;
    repeat (8) cyc();
    #1;
    chk("p5_count", 32'(delivered - d0), 32'd4);
    chk("p5_lasts", 32'(last_cnt - l0), 32'd1);

    // enable drops with a read in flight.
    cyc();
    push(32'h7); push(32'h11); push(32'h22);
    #1;
    chk("p6_rd_first", 32'(fifo_rd), 32'd1);
    cyc();
    enable = 1'b0;
    #1;
    chk("p6_rd_off", 32'(fifo_rd), 32'd0);
    d0 = delivered;
    for (int k = 0; k < 5; k++) begin
      cyc();
      #1;
      chk("p6_rd_off", 32'(fifo_rd), 32'd0);
      chk("p6_nonempty", 32'(fifo_empty), 32'd0);
      if (k == 0) begin
        chk("p6_valid", 32'(m_valid), 32'd1);
        chk("p6_data", m_data, 32'h7);
`ifdef STREAM_PARITY_EN
        chk("p6_parity", 32'(m_parity), 32'd1);
`endif
      end
    end
    chk("p6_count", 32'(delivered - d0), 32'd1);

    // Random enable, backpressure and FIFO fill.
    for (int k = 0; k < 600; k++) begin
      cyc();
      enable  = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if ((8'(wr_ptr - rd_ptr) < 8'd12) && ($urandom_range(0, 1) == 1)) push($urandom);
    end
    cyc();
    enable = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 100 && !(exp_ptr == wr_ptr && !busy); k++) cyc();
    #1;
    chk("drain_all", 32'(exp_ptr), 32'(wr_ptr));
    chk("drain_valid", 32'(m_valid), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
Name: fifo_stream_reader

Overview:
Drain-side controller for the team's 32-bit strobe FIFO (rd/wr/en strobes, empty/full flags, dataOut registered on the read edge). Issues FIFO read strobes and absorbs the one-cycle read latency in a 2-entry skid buffer. Presents words on a valid/ready stream with packet framing (m_last). Sits between the FIFO and any downstream stream consumer.

Parameters:
DATA_W, 32, word width; matches FIFO dataIn/dataOut.
PKT_LEN, 8, words per packet; m_last marks word PKT_LEN-1 of each packet; legal range 1..65535.

Ports:
clk  in  1  clock, rising-edge.
rst  in  1  reset, asynchronous, active-high.
enable  in  1  allow new FIFO reads; low = stop issuing reads, keep draining the buffer.
fifo_rd  out  1  FIFO read strobe.
fifo_en  out  1  FIFO enable; equals fifo_rd.
fifo_empty  in  1  FIFO empty flag; reflects FIFO count after the most recent edge.
fifo_dout  in  DATA_W  FIFO dataOut; valid the cycle after a read edge.
m_valid  out  1  output word valid.
m_ready  in  1  downstream accept.
m_data  out  DATA_W  output word.
m_last  out  1  final word of the current packet; qualified by m_valid.
busy  out  1  high while occ != 0 or inflight == 1.

Behaviour:
- Reset (async, immediate):
  - m_valid=0, m_data=0, m_last=0, busy=0.
  - Buffer occupancy occ=0, inflight=0, word counter wcnt=0.
  - fifo_rd=0 while rst is high.
- pop = m_valid & m_ready (combinational).
- Issue rule (combinational; includes the path m_ready -> fifo_rd):
  - fifo_rd = enable & !fifo_empty & ((occ + inflight - pop) < 2).
  - fifo_en = fifo_rd.
- inflight register: set to fifo_rd at each clk edge.
- Capture: when inflight=1, fifo_dout is written into the buffer at that edge.
  - Occupancy after the edge: occ_next = occ + inflight - pop; occ_next is never > 2.
- Buffer order:
  - Head register drives m_data; skid register holds the second word.
  - Strict FIFO order; no word is dropped or duplicated.
  - On pop with the skid occupied, skid moves to head.
  - If capture and pop happen in the same cycle, the captured word goes to head when head empties, otherwise to skid.
- m_valid = (occ != 0), registered. m_data holds steady while m_valid & !m_ready.
- Latency and throughput:
  - First fifo_rd to m_valid: 2 edges (read edge, then capture edge).
  - Sustained rate is 1 word/cycle with m_ready held high and the FIFO non-empty.
- Framing:
  - m_last = m_valid & (wcnt == PKT_LEN-1).
  - On pop, wcnt increments; it wraps to 0 after PKT_LEN-1.
  - With PKT_LEN=1, m_last = m_valid.
  - wcnt width is $clog2(PKT_LEN), minimum 1 bit.
- Boundaries:
  - FIFO empty: no read issued. A read issued on the last word is legal; fifo_empty then rises and stops further reads.
  - Buffer full (occ=2, no pop): fifo_rd=0.
  - enable falls with inflight=1: the in-flight word is still captured and presented; no new reads are issued.
  - Reset mid-stream: buffered and in-flight words are discarded; the FIFO pointers are the FIFO's own responsibility.
- Never asserts fifo_rd in a cycle where fifo_empty=1.

Optional Feature:
- Macro STREAM_PARITY_EN.
- Defined:
  - Adds output m_parity, 1 bit, equal to the even parity (XOR reduction) of m_data.
  - Computed at capture and stored per buffer entry, so it moves with its word.
  - Reset value 0.
- Undefined: port m_parity and its storage are absent; all other behaviour is identical.

Test Plan:
- Reset release, fifo_empty=1, enable=1 for 10 cycles -> fifo_rd=0, m_valid=0, busy=0 throughout.
- FIFO holds 0xA1,0xA2,0xA3, m_ready=1 -> fifo_rd high for 3 consecutive cycles; m_valid from edge 2 after the first rd; m_data=A1,A2,A3 on consecutive cycles; then m_valid=0.
- 5 words, m_ready=0 for 8 cycles -> exactly 2 reads issued, m_data=word0 held stable. Release m_ready -> words 0..4 delivered in order, no gap after the initial refill, no loss or duplicate.
- PKT_LEN=4, 9 words streamed -> m_last high on words 3 and 7 (0-based) only; word 8 has m_last=0 and wcnt=1 after.
- Assert rst mid-stream with occ=2 -> m_valid, m_data, m_last and busy go to 0 before the next edge; after release, the next word delivered reports wcnt restarted (m_last on the PKT_LEN-th word).
- enable dropped the cycle after a fifo_rd -> that word is still presented on m_data; fifo_rd stays 0 while the FIFO remains non-empty; with STREAM_PARITY_EN and data 0x00000007, m_parity=1.
